// File: rtl/present_cbc_ctrl.sv
// present_cbc_ctrl: block-chaining controller in front of a PRESENT-80 core.
// Accepts 64-bit blocks, hands them to the core with a one-cycle load
// pulse, waits for core_done (bounded by TIMEOUT_CYCLES) and returns the
// result on a valid/ready output port. All outputs are registered.
//
// Build option: define PRESENT_CBC_EN for CBC chaining (iv, chain register
// and saved ciphertext). Without it the block runs in ECB mode and iv is
// not used.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | s_ready high, waiting for an input block
// LOAD  | core inputs registered, core_load pulsed for this one cycle
// WAIT  | waiting for core_done, counting towards the timeout
// OUT   | m_valid high, result held until m_ready
module present_cbc_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        s_last,
  input  logic [79:0] key,
  input  logic [63:0] iv,
  input  logic        mode,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_last,
  output logic [63:0] core_idat,
  output logic [79:0] core_key,
  output logic        core_load,
  output logic        core_control,
  input  logic [63:0] core_odat,
  input  logic        core_done,
  output logic        err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s_ready_q, s_ready_d;
  logic            m_valid_q, m_valid_d;
  logic [63:0]     m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic            core_load_q, core_load_d;
  logic [63:0]     core_idat_q, core_idat_d;
  logic [79:0]     core_key_q, core_key_d;
  logic            core_control_q, core_control_d;
  logic            err_q, err_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            mode_eff;

`ifdef PRESENT_CBC_EN
  logic [63:0]     chain_q, chain_d;
  logic [63:0]     saved_q, saved_d;
  logic [63:0]     chain_eff;
`else
  logic            unused_iv;
  assign unused_iv = ^iv;
`endif

  // Next-state and registered-output logic; key/mode/iv only matter on the first block of a chain.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    s_ready_d      = s_ready_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_last_d       = m_last_q;
    core_load_d    = 1'b0;
    core_idat_d    = core_idat_q;
    core_key_d     = core_key_q;
    core_control_d = core_control_q;
    err_d          = err_q;
    first_d        = first_q;
    last_d         = last_q;
    mode_eff       = first_q ? mode : core_control_q;
`ifdef PRESENT_CBC_EN
    chain_d        = chain_q;
    saved_d        = saved_q;
    chain_eff      = first_q ? iv : chain_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          state_d        = ST_LOAD;
          s_ready_d      = 1'b0;
          core_load_d    = 1'b1;
          core_key_d     = first_q ? key : core_key_q;
          core_control_d = mode_eff;
          last_d         = s_last;
          first_d        = s_last;
`ifdef PRESENT_CBC_EN
          chain_d        = chain_eff;
          saved_d        = s_data;
          core_idat_d    = mode_eff ? s_data : (s_data ^ chain_eff);
`else
          core_idat_d    = s_data;
`endif
        end else begin
          s_ready_d = 1'b1;
        end
      end

      ST_LOAD: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        if (core_done) begin
          state_d   = ST_OUT;
          m_valid_d = 1'b1;
          m_last_d  = last_q;
`ifdef PRESENT_CBC_EN
          if (!core_control_q) begin
            m_data_d = core_odat;
            chain_d  = core_odat;
          end else begin
            m_data_d = core_odat ^ chain_q;
            chain_d  = saved_q;
          end
`else
          m_data_d  = core_odat;
`endif
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the chain: the next block restarts from iv with fresh key/mode.
          state_d   = ST_IDLE;
          s_ready_d = 1'b1;
          err_d     = 1'b1;
          first_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_OUT: begin
        if (m_ready) begin
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset leaves s_ready low for one cycle.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      s_ready_q      <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_last_q       <= 1'b0;
      core_load_q    <= 1'b0;
      core_idat_q    <= '0;
      core_key_q     <= '0;
      core_control_q <= 1'b0;
      err_q          <= 1'b0;
      first_q        <= 1'b1;
      last_q         <= 1'b0;
`ifdef PRESENT_CBC_EN
      chain_q        <= '0;
      saved_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      s_ready_q      <= s_ready_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
      core_load_q    <= core_load_d;
      core_idat_q    <= core_idat_d;
      core_key_q     <= core_key_d;
      core_control_q <= core_control_d;
      err_q          <= err_d;
      first_q        <= first_d;
      last_q         <= last_d;
`ifdef PRESENT_CBC_EN
      chain_q        <= chain_d;
      saved_q        <= saved_d;
`endif
    end
  end

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign core_load    = core_load_q;
  assign core_idat    = core_idat_q;
  assign core_key     = core_key_q;
  assign core_control = core_control_q;
  assign err          = err_q;

endmodule

// File: tb/tb_present_cbc_ctrl.sv
// Testbench for present_cbc_ctrl: a behavioural PRESENT-80 core model,
// a transaction-level CBC/ECB reference and a per-cycle compare process,
// followed by directed scenarios and a randomized block stream.
module tb_present_cbc_ctrl;

  logic        clk;
  logic        iReset;
  logic        s_valid, s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic [79:0] key;
  logic [63:0] iv;
  logic        mode;
  logic        m_valid, m_ready;
  logic [63:0] m_data;
  logic        m_last;
  logic [63:0] core_idat;
  logic [79:0] core_key;
  logic        core_load, core_control;
  logic [63:0] core_odat;
  logic        core_done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  bit dead = 0;
  bit rand_mr = 0;
  int lat_lo = 0;
  int lat_hi = 4;

  present_cbc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .iReset(iReset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .key(key), .iv(iv), .mode(mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_idat(core_idat), .core_key(core_key), .core_load(core_load),
    .core_control(core_control), .core_odat(core_odat), .core_done(core_done),
    .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- PRESENT-80 reference ----------------
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    return tbl[(15 - int'(x)) * 4 +: 4];
  endfunction

  function automatic logic [3:0] sbox4_inv(input logic [3:0] y);
    logic [3:0] r;
    r = '0;
    for (int v = 0; v < 16; v++) if (sbox4(4'(v)) == y) r = 4'(v);
    return r;
  endfunction

  function automatic logic [79:0] key_step(input logic [79:0] k, input int r);
    logic [79:0] n;
    n = {k[18:0], k[79:19]};
    n[79:76] = sbox4(n[79:76]);
    n[19:15] = n[19:15] ^ 5'(r);
    return n;
  endfunction

  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] kin);
    logic [63:0] s, t;
    logic [79:0] k;
    s = pt;
    k = kin;
    for (int r = 1; r < 32; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox4(s[n*4 +: 4]);
      t = '0;
      for (int b = 0; b < 63; b++) t[(b * 16) % 63] = s[b];
      t[63] = s[63];
      s = t;
      k = key_step(k, r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] present_dec(input logic [63:0] ct, input logic [79:0] kin);
    logic [63:0] s, t;
    logic [79:0] k;
    logic [63:0] rk [1:32];
    k = kin;
    rk[1] = k[79:16];
    for (int r = 1; r < 32; r++) begin
      k = key_step(k, r);
      rk[r+1] = k[79:16];
    end
    s = ct ^ rk[32];
    for (int r = 31; r >= 1; r--) begin
      t = '0;
      for (int b = 0; b < 63; b++) t[b] = s[(b * 16) % 63];
      t[63] = s[63];
      s = t;
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox4_inv(s[n*4 +: 4]);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_diff(input string name, input logic [63:0] act, input logic [63:0] not_exp);
    n_checks++;
    if (act === not_exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h must differ from %h", name, act, not_exp);
    end
  endtask

  // ---------------- core model ----------------
  logic [63:0] core_res;
  int          core_cd;
  bit          core_pend;
  initial begin
    logic cl, rs, real_done;
    core_done = 0;
    core_odat = '0;
    core_pend = 0;
    core_cd   = 0;
    core_res  = '0;
    forever begin
      @(posedge clk);
      cl = core_load;
      rs = iReset;
      #1;
      real_done = 0;
      core_done = 0;
      if (rs) begin
        core_pend = 0;
      end else begin
        if (core_pend) begin
          if (core_cd == 0) begin
            core_done = 1;
            real_done = 1;
            core_pend = 0;
          end else begin
            core_cd--;
          end
        end else if (cl !== 1'b1 && !dead && $urandom_range(0, 3) == 0) begin
          core_done = 1;
        end
        if (cl === 1'b1 && !dead) begin
          core_res  = core_control ? present_dec(core_idat, core_key) : present_enc(core_idat, core_key);
          core_cd   = int'($urandom_range(lat_hi, lat_lo));
          core_pend = 1;
        end
      end
      core_odat = real_done ? core_res : {$urandom, $urandom};
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  logic [63:0] exp_d [$];
  logic        exp_l [$];
  bit          m_first = 1;
  logic [79:0] m_key = '0;
  logic        m_mode = 0;
  bit          err_model = 0;
  bit          prev_acc = 0;
  logic [63:0] x_idat;
  logic [79:0] x_key;
  logic        x_mode;
`ifdef PRESENT_CBC_EN
  logic [63:0] m_chain = '0;
`endif

  initial begin
    logic [63:0] o;
    forever begin
      @(negedge clk);
      if (iReset) begin
        exp_d.delete();
        exp_l.delete();
        m_first   = 1;
        err_model = 0;
        prev_acc  = 0;
`ifdef PRESENT_CBC_EN
        m_chain   = '0;
`endif
      end else begin
        check("core_load", core_load, prev_acc);
        if (prev_acc) begin
          check("core_idat", core_idat, x_idat);
          check("core_key", core_key, x_key);
          check("core_control", core_control, x_mode);
        end
        prev_acc = 0;
        if (m_valid) begin
          check("s_ready in OUT", s_ready, 0);
          if (exp_d.size() == 0) begin
            check("m_valid unexpected", m_valid, 0);
          end else begin
            check("m_data", m_data, exp_d[0]);
            check("m_last", m_last, exp_l[0]);
            if (m_ready) begin
              void'(exp_d.pop_front());
              void'(exp_l.pop_front());
            end
          end
        end
        if (!dead) check("err", err, err_model);
        if (s_valid && s_ready) begin
          if (m_first) begin
            m_key  = key;
            m_mode = mode;
`ifdef PRESENT_CBC_EN
            m_chain = iv;
`endif
          end
`ifdef PRESENT_CBC_EN
          x_idat = m_mode ? s_data : (s_data ^ m_chain);
`else
          x_idat = s_data;
`endif
          x_key    = m_key;
          x_mode   = m_mode;
          prev_acc = 1;
          if (dead) begin
            m_first = 1;
          end else begin
`ifdef PRESENT_CBC_EN
            if (!m_mode) begin
              o = present_enc(s_data ^ m_chain, m_key);
              m_chain = o;
            end else begin
              o = present_dec(s_data, m_key) ^ m_chain;
              m_chain = s_data;
            end
`else
            o = m_mode ? present_dec(s_data, m_key) : present_enc(s_data, m_key);
`endif
            exp_d.push_back(o);
            exp_l.push_back(s_last);
            m_first = s_last;
          end
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_mr) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [63:0] d, input logic l, input logic [79:0] k,
                      input logic [63:0] v, input logic md);
    bit ok;
    ok = 0;
    s_data = d; s_last = l; key = k; iv = v; mode = md; s_valid = 1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1;
      tick();
    end
    s_valid = 0;
    s_data  = {$urandom, $urandom};
    check("block accepted", ok, 1);
  endtask

  task automatic get_out(input string name, output logic [63:0] d, output logic l);
    bit found;
    found = 0;
    d = 'x;
    l = 'x;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (m_valid) begin
        found = 1;
        d = m_data;
        l = m_last;
      end
    end
    check({name, " m_valid seen"}, found, 1);
    tick();
  endtask

  task automatic wait_load(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (core_load) found = 1;
    end
    check({name, " core_load seen"}, found, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " s_ready"}, s_ready, 0);
    check({tag, " m_valid"}, m_valid, 0);
    check({tag, " m_data"}, m_data, 0);
    check({tag, " m_last"}, m_last, 0);
    check({tag, " core_load"}, core_load, 0);
    check({tag, " core_idat"}, core_idat, 0);
    check({tag, " core_key"}, core_key, 0);
    check({tag, " core_control"}, core_control, 0);
    check({tag, " err"}, err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] gd, d0;
    logic        gl;
    bit          mv_seen;
    s_valid = 0; s_data = '0; s_last = 0; key = '0; iv = '0; mode = 0;
    m_ready = 1; iReset = 1;

    check("model enc k0 p0", present_enc(64'h0, 80'h0), 64'h5579C1387B228445);
    check("model enc k1 p1", present_enc(64'hFFFFFFFFFFFFFFFF, {80{1'b1}}), 64'h3333DCD3213210D2);
    check("model dec k0", present_dec(64'h5579C1387B228445, 80'h0), 64'h0);

    repeat (2) tick();
    iReset = 0;
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    check("s_ready after reset", s_ready, 1);
    tick();

    // single-block encrypt
    send(64'h0, 1, 80'h0, 64'h0, 0);
    get_out("enc1", gd, gl);
    check("enc1 m_data", gd, 64'h5579C1387B228445);
    check("enc1 m_last", gl, 1);

    // single-block decrypt
    send(64'h5579C1387B228445, 1, 80'h0, 64'h0, 1);
    get_out("dec1", gd, gl);
    check("dec1 m_data", gd, 64'h0);
    check("dec1 m_last", gl, 1);

    // two-block chain
    send(64'h0, 0, 80'h0, 64'h0, 0);
    get_out("chain1", gd, gl);
    check("chain1 m_data", gd, 64'h5579C1387B228445);
    check("chain1 m_last", gl, 0);
    send(64'h5579C1387B228445, 1, 80'h0, 64'h0, 0);
    get_out("chain2", gd, gl);
`ifdef PRESENT_CBC_EN
    check("chain2 m_data", gd, 64'h5579C1387B228445);
`else
    check_diff("chain2 ecb m_data", gd, 64'h5579C1387B228445);
`endif
    check("chain2 m_last", gl, 1);

    // backpressure
    m_ready = 0;
    send(64'h0, 1, 80'h0, 64'h0, 0);
    mv_seen = 0;
    for (int i = 0; i < 100 && !mv_seen; i++) begin
      @(negedge clk);
      if (m_valid) mv_seen = 1;
    end
    check("bp m_valid seen", mv_seen, 1);
    d0 = 64'h5579C1387B228445;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp m_valid held", m_valid, 1);
      check("bp m_data held", m_data, d0);
      check("bp s_ready low", s_ready, 0);
    end
    tick();
    m_ready = 1;
    @(negedge clk);
    check("bp no bypass s_ready", s_ready, 0);
    check("bp m_valid at handshake", m_valid, 1);
    @(negedge clk);
    check("bp s_ready after", s_ready, 1);
    check("bp m_valid after", m_valid, 0);
    tick();

    // timeout with a silent core
    dead = 1;
    send({$urandom, $urandom}, 0, {$urandom, $urandom, 16'($urandom)}, 64'hA5A5_0F0F_1234_8765, 0);
    wait_load("to");
    mv_seen = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (m_valid) mv_seen = 1;
    end
    check("to err before 16", err, 0);
    @(negedge clk);
    check("to err at 16", err, 1);
    check("to s_ready", s_ready, 1);
    check("to no m_valid", mv_seen | m_valid, 0);
    err_model = 1;
    dead = 0;
    tick();
    send(64'h0, 1, 80'h0, 64'h0, 0);
    get_out("to next", gd, gl);
    check("to next uses iv", gd, 64'h5579C1387B228445);
    check("to err sticky", err, 1);

    // randomized block stream
    rand_mr = 1;
    lat_lo = 0;
    lat_hi = 10;
    for (int b = 0; b < 60; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      send({$urandom, $urandom}, ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 3) == 0) ? 80'h0 : {$urandom, $urandom, 16'($urandom)},
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    rand_mr = 0;
    m_ready = 1;
    for (int i = 0; i < 200 && exp_d.size() > 0; i++) tick();
    check("random drain", exp_d.size(), 0);

    // reset in the middle of WAIT
    lat_lo = 10;
    lat_hi = 10;
    tick();
    send({$urandom, $urandom}, 0, 80'h0, 64'h0, 0);
    wait_load("rst");
    repeat (3) @(negedge clk);
    tick();
    iReset = 1;
    tick();
    iReset = 0;
    @(negedge clk);
    check_reset_vals("mid-wait reset");
    repeat (15) @(negedge clk);
    tick();
    lat_lo = 0;
    lat_hi = 4;
    send(64'h0, 1, 80'h0, 64'h0, 0);
    get_out("post reset", gd, gl);
    check("post reset m_data", gd, 64'h5579C1387B228445);
    check("post reset m_last", gl, 1);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/present_cbc_ctrl.md
PRESENT_CBC_CTRL -- requirements
Module: present_cbc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the maximum number of cycles to wait for core_done before aborting.
REQ-002 clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 iReset  input  1  reset, synchronous and active-high.
REQ-004 s_valid  input  1  input block is valid.
REQ-005 s_ready  output  1  the block is ready to accept an input block.
REQ-006 s_data  input  64  input block (plaintext when encrypting, ciphertext when decrypting).
REQ-007 s_last  input  1  this block is the last block of the chain.
REQ-008 key  input  80  cipher key.
REQ-009 iv  input  64  initialisation vector.
REQ-010 mode  input  1  0 = encrypt, 1 = decrypt.
REQ-011 m_valid  output  1  output block is valid.
REQ-012 m_ready  input  1  downstream accepts the output block.
REQ-013 m_data  output  64  output block.
REQ-014 m_last  output  1  the output block is the last block of the chain.
REQ-015 core_idat  output  64  block to the cipher core.
REQ-016 core_key  output  80  key to the cipher core.
REQ-017 core_load  output  1  single-cycle start pulse to the core.
REQ-018 core_control  output  1  0 = encrypt, 1 = decrypt, to the core.
REQ-019 core_odat  input  64  core result.
REQ-020 core_done  input  1  core result valid pulse.
REQ-021 err  output  1  sticky timeout flag.

Function
REQ-022 SHALL implement a state machine with states IDLE, LOAD, WAIT and OUT; all outputs SHALL be registered.
REQ-023 IDLE: s_ready=1; on s_valid&s_ready, go to LOAD.
- If this is the first block of a chain (after reset, after an s_last block, or after a timeout), SHALL sample key, mode and iv; the chain register takes iv.
REQ-024 On acceptance, SHALL register the core inputs:
- core_idat = s_data XOR chain when mode=0, or s_data when mode=1.
- core_key = sampled key; core_control = sampled mode.
- s_data SHALL be saved as the decrypt chain value.
REQ-025 LOAD: core_load=1 for exactly one cycle; go to WAIT and clear the wait counter.
REQ-026 WAIT: the counter increments each cycle.
- On core_done=1, SHALL sample core_odat in that same cycle.
- Encrypt: m_data = core_odat and chain becomes core_odat.
- Decrypt: m_data = core_odat XOR chain and chain becomes the saved s_data.
- m_last = the registered s_last; go to OUT.
REQ-027 WAIT: if the counter reaches TIMEOUT_CYCLES with no core_done, SHALL set err=1, mark the next block as the first of a chain, and go to IDLE with no m_valid.
REQ-028 OUT: m_valid=1, with m_data and m_last held stable until m_ready=1; then go to IDLE on the next cycle; there SHALL be no same-cycle bypass to s_ready.
REQ-029 core_idat, core_key and core_control SHALL stay stable from LOAD until leaving WAIT.
REQ-030 core_done SHALL be ignored in IDLE, LOAD and OUT.
REQ-031 s_ready SHALL be 0 in LOAD, WAIT and OUT.
REQ-032 mode, key and iv changes in the middle of a chain SHALL be ignored until the next first block.
REQ-033 err SHALL be cleared only by reset.

Reset
REQ-034 When iReset=1 at a clock edge, SHALL go to IDLE, regardless of state, including mid-WAIT.
REQ-035 Reset values:
- s_ready=0 in the reset cycle and 1 from the first cycle after reset.
- m_valid=0, m_data=0, m_last=0, core_load=0, core_idat=0, core_key=0, core_control=0, err=0, chain=0.
- The next block is the first of a chain.

Configuration
REQ-036 With PRESENT_CBC_EN defined, SHALL perform CBC chaining as specified above.
REQ-037 With PRESENT_CBC_EN undefined, SHALL run in ECB mode:
- core_idat = s_data and m_data = core_odat.
- iv is ignored, and the chain register and saved value are not built.

Verification (bench with PRESENT_CORE attached, PRESENT_CBC_EN defined unless stated)
REQ-038 Encrypt, single block: key=0, iv=0, mode=0, s_data=0, s_last=1 -> one core_load pulse, m_data=5579C1387B228445, m_last=1.
REQ-039 Decrypt, single block: key=0, iv=0, mode=1, s_data=5579C1387B228445 -> m_data=0000000000000000.
REQ-040 CBC encrypt, two blocks: key=0, iv=0, blocks 0 then 5579C1387B228445 (last) -> both m_data=5579C1387B228445. Without PRESENT_CBC_EN, the second output SHALL be different.
REQ-041 Backpressure: m_ready=0 for 10 cycles in OUT -> m_valid=1 and m_data stable throughout, s_ready=0; after m_ready=1, s_ready=1 one cycle later.
REQ-042 Timeout: core stub that never pulses core_done, TIMEOUT_CYCLES=16 -> err=1 at 16 cycles into WAIT, return to IDLE, no m_valid; the next block uses iv.
REQ-043 Reset mid-WAIT: iReset=1 for one cycle -> all outputs at reset values the next cycle and no m_valid; a new block then encrypts per REQ-038.
